// File: rtl/rr_sched_pkg.sv
// Shared types and helpers for the rr_sched4 round-robin arbiter.
package rr_sched_pkg;

  localparam int unsigned N_DEF = 4;
  localparam int unsigned ID_W  = $clog2(N_DEF);
  localparam int unsigned MAX_N = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // One-hot decode of an index; callers truncate to their own width.
  function automatic logic [MAX_N-1:0] onehot(input logic [2:0] k);
    return MAX_N'(1) << k;
  endfunction

endpackage

// File: rtl/rr_sched4_if.sv
// Request/grant bundle between the requesting masters and the arbiter.
interface rr_sched4_if #(
  parameter int unsigned N = 4
);
  localparam int unsigned IDW = $clog2(N);

  logic [N-1:0]   req;
  logic [N-1:0]   grant;
  logic           grant_valid;
  logic [IDW-1:0] grant_id;
  logic [N-1:0]   starve;

  modport master (output req, input grant, input grant_valid, input grant_id, input starve);
  modport slave  (input req, output grant, output grant_valid, output grant_id, output starve);
endinterface

// File: rtl/rr_pick.sv
// Rotating priority encoder: first set bit of req at or above ptr, wrapping.
module rr_pick #(
  parameter int unsigned N   = 4,
  parameter int unsigned IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic           any,
  output logic [IDW-1:0] idx
);

  logic [2*N-1:0] dbl;
  logic           found;

  // The upper copy of req supplies the wrapped-around candidates.
  always_comb begin
    dbl   = {req, req};
    any   = |req;
    idx   = '0;
    found = 1'b0;
    for (int j = 0; j < 2 * N; j++) begin
      if (!found && dbl[j] && (j >= int'(ptr))) begin
        found = 1'b1;
        idx   = IDW'(j % N);
      end
    end
  end

endmodule

// File: rtl/rr_sched4.sv
// N-way round-robin arbiter with bounded grant hold and per-requester
// starvation watchdog; grants are registered and one-hot.
module rr_sched4 import rr_sched_pkg::*; #(
  parameter int unsigned N        = N_DEF,
  parameter int unsigned HOLD_MAX = 3,
  parameter int unsigned WAIT_MAX = 16
) (
  input  logic         clock,
  input  logic         reset,
  rr_sched4_if.slave   bus
);

  localparam int unsigned IDW = $clog2(N);
  localparam int unsigned HW  = $clog2(HOLD_MAX + 1);
  localparam int unsigned WW  = $clog2(WAIT_MAX + 1);

  state_t         state, state_n;
  logic [N-1:0]   req_q;
  logic [N-1:0]   grant_n, own_oh, others, pick_req;
  logic [IDW-1:0] ptr, ptr_n, owner_n, pick_idx;
  logic [HW-1:0]  hold_cnt, hold_n;
  logic           pick_any, owner_req, force_rot;
  logic [WW-1:0]  wait_cnt [N];

  assign own_oh    = N'(onehot(3'(bus.grant_id)));
  assign owner_req = (state == GRANT) && ((req_q & own_oh) != '0);
  assign others    = req_q & ~own_oh;
  assign force_rot = owner_req && (hold_cnt == HW'(HOLD_MAX)) && (others != '0);
  assign pick_req  = force_rot ? others : req_q;

  rr_pick #(.N(N), .IDW(IDW)) u_pick (
    .req (pick_req),
    .ptr (ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  // Next-state, next-owner and next-grant decision.
  always_comb begin
    state_n = state;
    owner_n = bus.grant_id;
    ptr_n   = ptr;
    hold_n  = hold_cnt;
    grant_n = bus.grant;
    unique case (state)
      IDLE: begin
        grant_n = '0;
        owner_n = '0;
        if (pick_any) begin
          state_n = GRANT;
          owner_n = pick_idx;
          grant_n = N'(onehot(3'(pick_idx)));
          ptr_n   = (pick_idx == IDW'(N - 1)) ? '0 : pick_idx + IDW'(1);
          hold_n  = HW'(1);
        end
      end
      GRANT: begin
        if (!owner_req && !pick_any) begin
          state_n = IDLE;
          grant_n = '0;
          owner_n = '0;
        end else if (!owner_req || force_rot) begin
          owner_n = pick_idx;
          grant_n = N'(onehot(3'(pick_idx)));
          ptr_n   = (pick_idx == IDW'(N - 1)) ? '0 : pick_idx + IDW'(1);
          hold_n  = HW'(1);
        end else if (hold_cnt != HW'(HOLD_MAX)) begin
          hold_n = hold_cnt + HW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        grant_n = '0;
        owner_n = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= IDLE;
      req_q           <= '0;
      ptr             <= '0;
      hold_cnt        <= '0;
      bus.grant       <= '0;
      bus.grant_valid <= 1'b0;
      bus.grant_id    <= '0;
    end else begin
      state           <= state_n;
      req_q           <= bus.req;
      ptr             <= ptr_n;
      hold_cnt        <= hold_n;
      bus.grant       <= grant_n;
      bus.grant_valid <= |grant_n;
      bus.grant_id    <= owner_n;
    end
  end

  // Starvation watchdog: counts cycles a latched request goes ungranted.
  always_ff @(posedge clock) begin
    if (reset) begin
      bus.starve <= '0;
      for (int i = 0; i < N; i++) wait_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (req_q[i] && !bus.grant[i]) begin
          if (wait_cnt[i] != WW'(WAIT_MAX)) wait_cnt[i] <= wait_cnt[i] + WW'(1);
        end else begin
          wait_cnt[i] <= '0;
        end
        if (wait_cnt[i] == WW'(WAIT_MAX)) bus.starve[i] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rr_sched4.sv
// Directed and random self-checking bench for rr_sched4.
module tb_rr_sched4;

  logic clock = 1'b0;
  logic rst0;
  logic rst1;

  always #5 clock = ~clock;

  rr_sched4_if #(.N(4)) if0 ();
  rr_sched4_if #(.N(4)) if1 ();

  rr_sched4 #(.N(4), .HOLD_MAX(3), .WAIT_MAX(16)) dut (
    .clock (clock),
    .reset (rst0),
    .bus   (if0)
  );

  rr_sched4 #(.N(4), .HOLD_MAX(3), .WAIT_MAX(2)) dut_w (
    .clock (clock),
    .reset (rst1),
    .bus   (if1)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic reset0();
    rst0 = 1'b1;
    if0.req = '0;
    tick();
    tick();
    rst0 = 1'b0;
  endtask

  logic [3:0] seq1 [13];
  logic [3:0] prev_req;
  logic [3:0] new_req;

  initial begin
    rst0 = 1'b1;
    rst1 = 1'b1;
    if0.req = '0;
    if1.req = '0;
    seq1 = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0010,
             4'b0100, 4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b1000, 4'b0001};

    // Reset state
    reset0();
    check("rst_grant", 32'(if0.grant), 32'h0);
    check("rst_valid", 32'(if0.grant_valid), 32'h0);
    check("rst_id", 32'(if0.grant_id), 32'h0);
    check("rst_starve", 32'(if0.starve), 32'h0);

    // All four requesting: rotation every HOLD_MAX cycles
    if0.req = 4'b1111;
    tick();
    check("all_latch", 32'(if0.grant), 32'h0);
    for (int i = 0; i < 13; i++) begin
      tick();
      check($sformatf("all_seq%0d", i), 32'(if0.grant), 32'(seq1[i]));
    end
    check("all_starve", 32'(if0.starve), 32'h0);

    // Single persistent requester keeps the grant
    reset0();
    if0.req = 4'b0100;
    tick();
    check("solo_edge1", 32'(if0.grant), 32'h0);
    tick();
    check("solo_grant", 32'(if0.grant), 32'h4);
    check("solo_id", 32'(if0.grant_id), 32'h2);
    check("solo_valid", 32'(if0.grant_valid), 32'h1);
    for (int i = 0; i < 50; i++) begin
      tick();
      check("solo_hold", 32'(if0.grant), 32'h4);
    end

    // Owner drop hands over with no idle bubble, then goes idle
    reset0();
    if0.req = 4'b0011;
    tick();
    tick();
    check("ho_first", 32'(if0.grant), 32'h1);
    if0.req = 4'b0010;
    tick();
    check("ho_still0", 32'(if0.grant), 32'h1);
    tick();
    check("ho_next", 32'(if0.grant), 32'h2);
    check("ho_id", 32'(if0.grant_id), 32'h1);
    if0.req = 4'b0000;
    tick();
    check("ho_keep1", 32'(if0.grant), 32'h2);
    tick();
    check("ho_idle", 32'(if0.grant), 32'h0);
    check("ho_idle_v", 32'(if0.grant_valid), 32'h0);
    check("ho_idle_id", 32'(if0.grant_id), 32'h0);

    // Reset mid-grant returns priority to index 0
    reset0();
    if0.req = 4'b1111;
    for (int i = 0; i < 5; i++) tick();
    check("mr_pre", 32'(if0.grant), 32'h2);
    rst0 = 1'b1;
    tick();
    check("mr_rst", 32'(if0.grant), 32'h0);
    check("mr_rst_v", 32'(if0.grant_valid), 32'h0);
    rst0 = 1'b0;
    tick();
    check("mr_latch", 32'(if0.grant), 32'h0);
    tick();
    check("mr_first", 32'(if0.grant), 32'h1);

    // Short watchdog instance: requester 1 starves while 0 holds
    tick();
    rst1 = 1'b0;
    if1.req = 4'b0011;
    tick();
    tick();
    check("wd_g0", 32'(if1.grant), 32'h1);
    check("wd_s_e2", 32'(if1.starve), 32'h0);
    tick();
    tick();
    check("wd_g0_hold", 32'(if1.grant), 32'h1);
    check("wd_s1_set", 32'(if1.starve), 32'h2);
    tick();
    check("wd_g1", 32'(if1.grant), 32'h2);
    check("wd_s_after", 32'(if1.starve), 32'h2);
    tick();
    check("wd_s_sticky", 32'(if1.starve), 32'h2);

    // Random requests: one-hot grant, only to latched requesters, no starvation
    reset0();
    prev_req = '0;
    for (int c = 0; c < 10000; c++) begin
      new_req = 4'($urandom);
      if0.req = new_req;
      tick();
      check("rnd_onehot", 32'($countones(if0.grant) <= 1), 32'h1);
      check("rnd_subset", 32'(if0.grant & ~prev_req), 32'h0);
      check("rnd_valid", 32'(if0.grant_valid), 32'(|if0.grant));
      check("rnd_starve", 32'(if0.starve), 32'h0);
      prev_req = new_req;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
